choose_best_fixed_param: RTL and testbench
==========================================

// Module: choose_best_fixed_param
// PURPOSE
//   Selects the FLAC fixed-predictor order with the smallest sum of absolute residuals over
//   each block of BLOCK_SIZE samples. Takes NUM_ORDERS parallel residual streams, one per
//   FixedEncoderOrderN instance, and skips each order's warm-up samples. Supports a
//   per-block order mask and streams back-to-back blocks with no gap. Feeds the frame writer.
// PARAMETERS
//   DATA_W      16    residual width, signed two's complement
//   BLOCK_SIZE  4096  enabled samples per block; must be >= NUM_ORDERS
//   NUM_ORDERS  5     number of candidate orders, 1..5 (order k on lane k)
//   ACC_W       28    accumulator width (DATA_W + clog2(BLOCK_SIZE))
// PORTS
//   iClock      in   1                     system clock, rising edge
//   iReset      in   1                     asynchronous, active-high reset
//   iEnable     in   1                     residual lanes valid this cycle; low = stall
//   iResidual   in   NUM_ORDERS*DATA_W     packed residuals, lane k = bits [k*DATA_W +: DATA_W]
//   iOrderMask  in   NUM_ORDERS            1 = order is a candidate; sampled on block's first sample
//   oBest       out  3                     winning order index
//   oBestSum    out  ACC_W                 winning order's sum of absolute residuals
//   oValid      out  1                     one-cycle pulse: oBest/oBestSum hold a new result
// BEHAVIOUR
//   Reset
//   - Asynchronous. oBest=0, oBestSum=0, oValid=0.
//   - Clears the sample index, all accumulators, the snapshot and the stored mask.
//   Counting and accumulation
//   - Sample index idx runs 0..BLOCK_SIZE-1. It advances only on edges with iEnable=1 and
//     wraps to 0 after BLOCK_SIZE-1.
//   - iEnable=0 freezes idx and all accumulators. oValid still fires if it was already scheduled.
//   - Abs: |r| is unsigned DATA_W bits, so |-2^(DATA_W-1)| = 2^(DATA_W-1) exactly.
//   - Lane k adds |r_k| only when idx >= k (warm-up exclusion).
//   - Accumulators saturate at 2^ACC_W-1 and never wrap.
//   Order mask
//   - At idx==0 with iEnable=1, iOrderMask is latched for the whole block.
//   - Bit 0 is forced to 1, so order 0 is always a candidate.
//   - Mask changes mid-block have no effect.
//   Block end
//   - On the edge with iEnable=1 and idx==BLOCK_SIZE-1 (edge E), each accumulator's final
//     value (including this sample) is copied to a snapshot. The mask is copied with it.
//   - On that same edge E, the live accumulators are cleared to 0.
//   - The next block's first sample may arrive on the very next edge; back-to-back is required.
//   - Compare: minimum snapshot sum over masked-in orders. On a tie, the lowest order index wins.
//   - Edge E+1: oBest and oBestSum are registered and oValid=1 for exactly that one cycle.
//     Result latency is 1 edge after the last sample and does not depend on iEnable.
//   - oBest/oBestSum hold their value until the next result.
//   Reset mid-block
//   - The partial block is discarded and a pending oValid is cancelled.
//   - The first enabled sample after reset release is idx 0.
//   Alignment
//   - Upstream encoders and lane latencies are already aligned.
//   - The block assumes lane k at idx j carries order k's residual for sample j of the block.
// TESTING
//   1. DC input: all samples 100 -> order0 sum=409600, orders1-4 sums=0.
//      Expect oValid, oBest=1 (tie rule), oBestSum=0.
//   2. Linear ramp: sample=i -> order1 sum=4095, orders2-4=0. Expect oBest=2, oBestSum=0.
//   3. Warm-up: lane 4 drives 1000 at idx 0..3 and 0 after; other lanes drive 1.
//      Expect oBest=4, oBestSum=0.
//   4. Saturation/abs: order0 lane held at -32768 for all 4096 samples (ACC_W=28).
//      Expect sum=134217728 and no overflow. Repeat with ACC_W=16: expect 65535.
//   5. Back-to-back and stall: two blocks, iEnable low for random gaps in the 1st block.
//      Expect two oValid pulses, each 1 edge after that block's last enabled sample,
//      with the correct independent results.
//   6. Mask and reset: mask=5'b10100 on the ramp block -> expect oBest=2.
//      Assert iReset at idx 2000 -> no oValid; the next full block produces a clean result.

Source files
------------

// File: rtl/choose_best_fixed_param.sv
// Picks the fixed-predictor order with the smallest saturating sum of absolute residuals
// per block. Lane k skips its first k samples; the result is registered one edge after block end.
module choose_best_fixed_param #(
  parameter int DATA_W     = 16,
  parameter int BLOCK_SIZE = 4096,
  parameter int NUM_ORDERS = 5,
  parameter int ACC_W      = 28
) (
  input  logic                         iClock,
  input  logic                         iReset,
  input  logic                         iEnable,
  input  logic [NUM_ORDERS*DATA_W-1:0] iResidual,
  input  logic [NUM_ORDERS-1:0]        iOrderMask,
  output logic [2:0]                   oBest,
  output logic [ACC_W-1:0]             oBestSum,
  output logic                         oValid
);

  localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q [NUM_ORDERS];
  logic [ACC_W-1:0]      acc_d [NUM_ORDERS];
  logic [ACC_W-1:0]      snap_q [NUM_ORDERS];
  logic [ACC_W-1:0]      snap_d [NUM_ORDERS];
  logic [NUM_ORDERS-1:0] mask_q, mask_d;
  logic [NUM_ORDERS-1:0] snap_mask_q, snap_mask_d;
  logic                  pend_q, pend_d;
  logic [2:0]            best_q, best_d;
  logic [ACC_W-1:0]      best_sum_q, best_sum_d;
  logic                  valid_q, valid_d;

  logic [DATA_W-1:0]     mag [NUM_ORDERS];
  logic [ACC_W:0]        wide [NUM_ORDERS];
  logic [ACC_W-1:0]      acc_next [NUM_ORDERS];
  logic [NUM_ORDERS-1:0] blk_mask;
  logic                  last_sample;
  logic [2:0]            cand_idx;
  logic [ACC_W-1:0]      cand_sum;

  // Accumulation, block-end snapshot and mask capture
  always_comb begin
    last_sample = iEnable && (idx_q == LAST_IDX);
    // The mask is taken live on the first sample so a one-sample block still sees it
    blk_mask    = (idx_q == '0) ? (iOrderMask | NUM_ORDERS'(1)) : mask_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    snap_mask_d = snap_mask_q;
    pend_d      = last_sample;
    for (int unsigned k = 0; k < NUM_ORDERS; k++) begin
      mag[k]      = iResidual[k*DATA_W+DATA_W-1] ? (DATA_W'(0) - iResidual[k*DATA_W +: DATA_W])
                                                 : iResidual[k*DATA_W +: DATA_W];
      wide[k]     = {1'b0, acc_q[k]} + (ACC_W+1)'(mag[k]);
      acc_next[k] = (32'(idx_q) >= k) ? (wide[k][ACC_W] ? ACC_MAX : wide[k][ACC_W-1:0])
                                      : acc_q[k];
      acc_d[k]    = acc_q[k];
      snap_d[k]   = snap_q[k];
    end
    if (iEnable) begin
      idx_d = last_sample ? '0 : idx_q + IDX_W'(1);
      if (idx_q == '0) mask_d = blk_mask;
      if (last_sample) snap_mask_d = blk_mask;
      for (int unsigned k = 0; k < NUM_ORDERS; k++) begin
        acc_d[k] = last_sample ? '0 : acc_next[k];
        if (last_sample) snap_d[k] = acc_next[k];
      end
    end
  end

  // Minimum over the snapshot; strict '<' keeps the lowest index on a tie
  always_comb begin
    cand_idx   = '0;
    cand_sum   = snap_q[0];
    for (int unsigned k = 1; k < NUM_ORDERS; k++) begin
      if (snap_mask_q[k] && (snap_q[k] < cand_sum)) begin
        cand_idx = 3'(k);
        cand_sum = snap_q[k];
      end
    end
    best_d     = pend_q ? cand_idx : best_q;
    best_sum_d = pend_q ? cand_sum : best_sum_q;
    valid_d    = pend_q;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      idx_q       <= '0;
      mask_q      <= '0;
      snap_mask_q <= '0;
      pend_q      <= 1'b0;
      best_q      <= '0;
      best_sum_q  <= '0;
      valid_q     <= 1'b0;
      for (int unsigned k = 0; k < NUM_ORDERS; k++) begin
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      snap_mask_q <= snap_mask_d;
      pend_q      <= pend_d;
      best_q      <= best_d;
      best_sum_q  <= best_sum_d;
      valid_q     <= valid_d;
      for (int unsigned k = 0; k < NUM_ORDERS; k++) begin
        acc_q[k]  <= acc_d[k];
        snap_q[k] <= snap_d[k];
      end
    end
  end

  assign oBest    = best_q;
  assign oBestSum = best_sum_q;
  assign oValid   = valid_q;

endmodule

// File: tb/tb_choose_best_fixed_param.sv
// Directed and randomized blocks for choose_best_fixed_param, run on a 28-bit and a
// 16-bit accumulator instance side by side against a whole-block arithmetic model.
module tb_choose_best_fixed_param;

  localparam int DW = 16;
  localparam int BS = 4096;
  localparam int NO = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NO*DW-1:0]  res;
  logic [NO-1:0]     mask;
  logic [2:0]        best_a, best_b;
  logic [27:0]       sum_a;
  logic [15:0]       sum_b;
  logic              val_a, val_b;

  always #5 clk = ~clk;

  choose_best_fixed_param #(.DATA_W(DW), .BLOCK_SIZE(BS), .NUM_ORDERS(NO), .ACC_W(28)) dut_a (
    .iClock(clk), .iReset(rst), .iEnable(en), .iResidual(res), .iOrderMask(mask),
    .oBest(best_a), .oBestSum(sum_a), .oValid(val_a));

  choose_best_fixed_param #(.DATA_W(DW), .BLOCK_SIZE(BS), .NUM_ORDERS(NO), .ACC_W(16)) dut_b (
    .iClock(clk), .iReset(rst), .iEnable(en), .iResidual(res), .iOrderMask(mask),
    .oBest(best_b), .oBestSum(sum_b), .oValid(val_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic signed [DW-1:0] blk [NO][BS];

  logic [63:0] exp_cyc[$], exp_ba[$], exp_sa[$], exp_bb[$], exp_sb[$];
  logic [63:0] oa_cyc[$], oa_b[$], oa_s[$];
  logic [63:0] ob_cyc[$], ob_b[$], ob_s[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NO*DW-1:0] rnd_res();
    logic [NO*DW-1:0] p;
    for (int k = 0; k < NO; k++) p[k*DW +: DW] = DW'($urandom);
    return p;
  endfunction

  function automatic logic [NO*DW-1:0] pack(input int j);
    logic [NO*DW-1:0] p;
    for (int k = 0; k < NO; k++) p[k*DW +: DW] = blk[k][j];
    return p;
  endfunction

  // One clock edge; result pulses are logged with the edge number they appear after
  task automatic tick(input logic e, input logic [NO*DW-1:0] r, input logic [NO-1:0] m);
    en = e; res = r; mask = m;
    @(posedge clk);
    #1;
    cyc++;
    if (val_a === 1'b1) begin oa_cyc.push_back(cyc); oa_b.push_back(best_a); oa_s.push_back(sum_a); end
    if (val_b === 1'b1) begin ob_cyc.push_back(cyc); ob_b.push_back(best_b); ob_s.push_back(sum_b); end
  endtask

  // Whole-block reference: sum |r| from sample k onward, clamp, then pick the lowest-index minimum
  task automatic model(input logic [NO-1:0] m, input int accw, output int b, output longint s);
    longint tot [NO];
    longint cap;
    longint v;
    cap = (longint'(1) << accw) - 1;
    for (int k = 0; k < NO; k++) begin
      tot[k] = 0;
      for (int j = k; j < BS; j++) begin
        v = longint'(blk[k][j]);
        tot[k] += (v < 0) ? -v : v;
      end
      if (tot[k] > cap) tot[k] = cap;
    end
    b = 0;
    s = tot[0];
    for (int k = 1; k < NO; k++)
      if (m[k] && tot[k] < s) begin b = k; s = tot[k]; end
  endtask

  task automatic feed(input logic [NO-1:0] m, input bit gaps, input bit jitter,
                      input int stop_at, input bit want);
    int ba, bb;
    longint sa, sb;
    for (int j = 0; j < BS; j++) begin
      if (j == stop_at) return;
      if (gaps && $urandom_range(0, 15) == 0)
        repeat ($urandom_range(1, 3)) tick(1'b0, rnd_res(), NO'($urandom));
      tick(1'b1, pack(j), (j == 0 || !jitter) ? m : NO'($urandom));
    end
    if (want) begin
      model(m, 28, ba, sa);
      model(m, 16, bb, sb);
      exp_cyc.push_back(cyc + 1);
      exp_ba.push_back(ba); exp_sa.push_back(sa);
      exp_bb.push_back(bb); exp_sb.push_back(sb);
    end
  endtask

  task automatic check_results(input string tag);
    logic [63:0] e_c, e_ba, e_sa, e_bb, e_sb;
    check({tag, "_npulse_a"}, oa_cyc.size(), exp_cyc.size());
    check({tag, "_npulse_b"}, ob_cyc.size(), exp_cyc.size());
    while (exp_cyc.size() > 0) begin
      e_c = exp_cyc.pop_front();
      e_ba = exp_ba.pop_front(); e_sa = exp_sa.pop_front();
      e_bb = exp_bb.pop_front(); e_sb = exp_sb.pop_front();
      if (oa_cyc.size() > 0) begin
        check({tag, "_edge_a"}, oa_cyc.pop_front(), e_c);
        check({tag, "_best_a"}, oa_b.pop_front(), e_ba);
        check({tag, "_sum_a"},  oa_s.pop_front(), e_sa);
      end
      if (ob_cyc.size() > 0) begin
        check({tag, "_edge_b"}, ob_cyc.pop_front(), e_c);
        check({tag, "_best_b"}, ob_b.pop_front(), e_bb);
        check({tag, "_sum_b"},  ob_s.pop_front(), e_sb);
      end
    end
    oa_cyc.delete(); oa_b.delete(); oa_s.delete();
    ob_cyc.delete(); ob_b.delete(); ob_s.delete();
  endtask

  task automatic fill_random();
    int amp;
    for (int k = 0; k < NO; k++) begin
      amp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(0, 32767);
      for (int j = 0; j < BS; j++) blk[k][j] = DW'($urandom_range(0, 2 * amp) - amp);
    end
  endtask

  task automatic fill_ramp();
    for (int j = 0; j < BS; j++) begin
      blk[0][j] = DW'(j);
      blk[1][j] = 16'sd1;
      for (int k = 2; k < NO; k++) blk[k][j] = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_best_a"},  best_a, 0);
    check({tag, "_sum_a"},   sum_a,  0);
    check({tag, "_valid_a"}, val_a,  0);
    check({tag, "_best_b"},  best_b, 0);
    check({tag, "_sum_b"},   sum_b,  0);
    check({tag, "_valid_b"}, val_b,  0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; res = '0; mask = '0;
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;

    // DC: only order 0 sees the constant; tie among zero sums goes to order 1
    for (int j = 0; j < BS; j++) begin
      blk[0][j] = 16'sd100;
      for (int k = 1; k < NO; k++) blk[k][j] = '0;
    end
    feed(5'b11111, 1'b0, 1'b0, -1, 1'b1);
    tick(1'b0, '0, '0);
    check_results("dc");

    fill_ramp();
    feed(5'b11111, 1'b0, 1'b0, -1, 1'b1);
    tick(1'b0, '0, '0);
    check_results("ramp");

    // Warm-up: lane 4's nonzero samples all fall before its first counted sample
    for (int j = 0; j < BS; j++) begin
      for (int k = 0; k < 4; k++) blk[k][j] = 16'sd1;
      blk[4][j] = (j < 4) ? 16'sd1000 : 16'sd0;
    end
    feed(5'b11111, 1'b0, 1'b0, -1, 1'b1);
    tick(1'b0, '0, '0);
    check_results("warmup");

    // Most negative residual on order 0; empty mask still leaves order 0 in play
    fill_random();
    for (int j = 0; j < BS; j++) blk[0][j] = -16'sd32768;
    feed(5'b00000, 1'b0, 1'b0, -1, 1'b1);
    tick(1'b0, '0, '0);
    check_results("satabs");

    // Back-to-back random blocks, stalls and mid-block mask noise in the first
    for (int p = 0; p < 2; p++) begin
      fill_random();
      feed(NO'($urandom), 1'b1, 1'b1, -1, 1'b1);
      fill_random();
      feed(NO'($urandom), 1'b0, 1'b1, -1, 1'b1);
      repeat (3) tick(1'b0, rnd_res(), NO'($urandom));
      check_results("b2b");
    end

    fill_ramp();
    feed(5'b10100, 1'b0, 1'b0, -1, 1'b1);
    tick(1'b0, '0, '0);
    check_results("mask");

    // Reset part-way through a block discards it
    fill_random();
    feed(5'b11111, 1'b0, 1'b0, 2000, 1'b0);
    rst = 1'b1;
    #2;
    check_reset_outputs("midrst");
    repeat (2) tick(1'b0, rnd_res(), '1);
    rst = 1'b0;
    repeat (3) tick(1'b0, rnd_res(), '1);
    check_results("midrst");

    // Reset between the last sample and the result edge cancels the pulse
    fill_random();
    feed(5'b11111, 1'b0, 1'b0, -1, 1'b0);
    rst = 1'b1;
    repeat (2) tick(1'b0, rnd_res(), '1);
    rst = 1'b0;
    repeat (2) tick(1'b0, rnd_res(), '1);
    check_results("cancel");

    fill_random();
    feed(NO'($urandom), 1'b1, 1'b0, -1, 1'b1);
    repeat (3) tick(1'b0, rnd_res(), NO'($urandom));
    check_results("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
